tx_unit: RTL and testbench
==========================

Name: tx_unit

Overview:
Serial transmitter for the MiniUart, the counterpart to the receive unit. Accepts bytes from the CPU bus interface into a one-byte holding register and shifts them out on TxD as 8N1 frames: start bit, 8 data bits LSB first, 1 stop bit. Bit timing comes from the same oversampling enable strobe that drives the receiver, so both directions share one baud generator. Provides a buffer-empty status, a busy flag and a frame-done interrupt pulse for the interrupt controller.

Parameters:
TICKS, 8, number of en_tx strobes per bit period; must match the receiver oversampling ratio and be ≥2.
CW, 3, width of the tick counter; must satisfy 2^CW ≥ TICKS.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en_tx  input  1  oversampling enable strobe, one clk wide, shared with receiver
d_in  input  8  byte to transmit
load  input  1  write strobe; captures d_in when ts=1
ts  output  1  transmit status: 1 = holding register empty, can accept a byte
busy  output  1  1 while a frame is on the line (state != IDLE)
txd  output  1  serial output, idle high
uart_int_out  output  1  one-clk pulse when a frame's stop bit completes

Behaviour:
- Reset (async, immediate, including mid-frame): txd=1, state=IDLE, hold_full=0 so ts=1, busy=0, uart_int_out=0, tick counter=0, bit counter=0, shift register=0.
- Holding register: a rising clk with load=1 and hold_full=0 captures d_in; hold_full=1 from the next cycle. load while hold_full=1 is ignored: the byte is dropped and the held data is unchanged. ts=~hold_full, driven from a register.
- FSM states are IDLE, START, BITS, STOP. All FSM, counter and txd updates occur only on cycles with en_tx=1, except load capture and reset.
- IDLE: on en_tx with hold_full=1: shreg<=hold, hold_full<=0, txd<=0, tick<=0, state<=START. Otherwise txd stays 1.
- START: on en_tx: if tick==TICKS-1, then txd<=shreg[0], bit<=0, tick<=0, state<=BITS; else tick<=tick+1. The start bit therefore lasts exactly TICKS strobe intervals.
- BITS: on en_tx with tick==TICKS-1:
  - if bit==7: txd<=1, state<=STOP.
  - else: shreg<=shreg>>1, txd<=next bit, bit<=bit+1.
  - tick<=0 in both cases; otherwise tick<=tick+1.
- STOP: on en_tx with tick==TICKS-1:
  - uart_int_out=1 for that one clk.
  - if hold_full=1, go back-to-back with no idle gap: same actions as the IDLE transfer, state<=START.
  - else state<=IDLE.
- Frame length: exactly 10*TICKS en_tx strobes. Data is sent LSB first.
- Simultaneous events:
  - load in the same cycle as a hold→shreg transfer: the transfer uses the old hold content and the load is ignored, because hold_full was 1 at that edge.
  - load into an empty hold during the IDLE en_tx cycle: the transfer occurs on the next en_tx.
  - After a transfer, ts=1 again mid-frame, so the CPU can queue the next byte.
- The data path holds 8 bits; the bit counter is 3 bits; the tick counter is CW bits. No parity, no break generation.
- en_tx stuck at 0 freezes the FSM with txd held at its current level. Loads still work.

Test Plan:
- Reset, then idle with en_tx every cycle, TICKS=8 -> txd=1, ts=1, busy=0, uart_int_out=0 indefinitely.
- Load 0x55 with en_tx every cycle -> txd=0 for 8 cycles, then 1,0,1,0,1,0,1,0 each held 8 cycles, then 1 for 8 cycles. uart_int_out pulses once at the end of the stop bit, then busy=0.
- Load 0xA3, then load 0x0F while the first frame is in its data bits -> two contiguous 80-cycle frames with no idle cycles between them. ts=0 only between the second load and its transfer. Two interrupt pulses.
- Load 0x11, then 0x22 and 0x33 back-to-back while hold_full=1 -> 0x33 is dropped and only 0x11 and 0x22 appear on the line.
- en_tx every 4th cycle, load 0xFF -> each bit lasts 32 clk cycles and the frame lasts 320 cycles.
- Assert rst during data bit 3 of a 0x00 frame -> txd=1 immediately (async). After release, ts=1, busy=0, and no interrupt pulse occurs.

Source files
------------

// File: rtl/tx_unit.sv
// MiniUart serial transmitter: one-byte holding register feeding an 8N1 shifter
// clocked by the oversampling strobe shared with the receiver.
module tx_unit #(
  parameter int TICKS = 8,
  parameter int CW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tx,
  input  logic [7:0] d_in,
  input  logic       load,
  output logic       ts,
  output logic       busy,
  output logic       txd,
  output logic       uart_int_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BITS  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS - 1);
  localparam logic [CW-1:0] TICK_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TICK_ZERO = {CW{1'b0}};

  state_t      state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        txd_q, txd_d;
  logic        ts_q, ts_d;
  logic        busy_q, busy_d;
  logic        int_q, int_d;
  logic        tick_end_s;

  assign tick_end_s = (tick_q == TICK_LAST);

  // Next-state logic for the holding register, frame FSM and registered outputs
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = txd_q;
    int_d       = 1'b0;

    // Loads and transfers are mutually exclusive: one needs an empty hold, the other a full one
    if (load && !hold_full_q) begin
      hold_d      = d_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    if (en_tx) begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            txd_d       = 1'b0;
            tick_d      = TICK_ZERO;
            state_d     = START;
          end else begin
            txd_d = 1'b1;
          end
        end
        START: begin
          if (tick_end_s) begin
            txd_d   = shreg_q[0];
            bit_d   = 3'd0;
            tick_d  = TICK_ZERO;
            state_d = BITS;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        BITS: begin
          if (tick_end_s) begin
            tick_d = TICK_ZERO;
            if (bit_q == 3'd7) begin
              txd_d   = 1'b1;
              state_d = STOP;
            end else begin
              shreg_d = {1'b0, shreg_q[7:1]};
              txd_d   = shreg_q[1];
              bit_d   = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_end_s) begin
            int_d  = 1'b1;
            tick_d = TICK_ZERO;
            // A queued byte starts immediately so consecutive frames have no idle gap
            if (hold_full_q) begin
              shreg_d     = hold_q;
              hold_full_d = 1'b0;
              txd_d       = 1'b0;
              state_d     = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
          tick_d  = TICK_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    ts_d   = ~hold_full_d;
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= TICK_ZERO;
      bit_q       <= 3'd0;
      shreg_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      ts_q        <= 1'b1;
      busy_q      <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      ts_q        <= ts_d;
      busy_q      <= busy_d;
      int_q       <= int_d;
    end
  end

  assign ts           = ts_q;
  assign busy         = busy_q;
  assign txd          = txd_q;
  assign uart_int_out = int_q;

endmodule

// File: tb/tb_tx_unit.sv
// Bench for tx_unit: fixed vector table, directed multi-cycle sequences and random
// traffic, all checked against a frame-level reference model.
module tb_tx_unit;
  localparam int TICKS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_tx = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d_in = 8'd0;
  logic       ts, busy, txd, uart_int_out;

  int checks = 0;
  int failures = 0;

  // Reference model: a frame is a 10-level sequence indexed by strobes since transfer
  bit         m_full;
  logic [7:0] m_hold;
  bit         m_active;
  int         m_strobe;
  logic [7:0] m_byte;
  bit         m_int;
  int         cnt_int, cnt_busy;

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       en;
    logic       txd;
    logic       ts;
    logic       busy;
    logic       irq;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  tx_unit #(.TICKS(TICKS), .CW(3)) dut (
    .clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in), .load(load),
    .ts(ts), .busy(busy), .txd(txd), .uart_int_out(uart_int_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic model_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_strobe / TICKS;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  task automatic model_reset();
    m_full = 0; m_hold = 8'd0; m_active = 0; m_strobe = 0; m_byte = 8'd0; m_int = 0;
  endtask

  task automatic model_update(input logic ld, input logic [7:0] din, input logic en);
    bit         pre_full;
    logic [7:0] pre_hold;
    pre_full = m_full;
    pre_hold = m_hold;
    m_int = 0;
    if (en) begin
      if (m_active) begin
        m_strobe++;
        if (m_strobe == 10 * TICKS) begin
          m_int = 1;
          m_active = 0;
        end
      end
      if (!m_active && pre_full) begin
        m_active = 1;
        m_strobe = 0;
        m_byte = pre_hold;
        m_full = 0;
      end
    end
    if (ld && !pre_full) begin
      m_hold = din;
      m_full = 1;
    end
  endtask

  task automatic step(input logic ld, input logic [7:0] din, input logic en);
    load = ld;
    d_in = din;
    en_tx = en;
    @(posedge clk);
    model_update(ld, din, en);
    #1;
    chk("txd", txd, model_txd());
    chk("ts", ts, !m_full);
    chk("busy", busy, m_active);
    chk("uart_int_out", uart_int_out, m_int);
    cnt_int += uart_int_out;
    cnt_busy += busy;
  endtask

  task automatic drain(input int period, input int maxcyc);
    int c = 0;
    while ((m_active || m_full) && c < maxcyc) begin
      step(1'b0, 8'h00, (c % period) == 0);
      c++;
    end
    chk("drain_idle", m_active, 0);
  endtask

  task automatic do_reset();
    load = 1'b0; en_tx = 1'b0; d_in = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("rst_txd", txd, 1); chk("rst_ts", ts, 1);
    chk("rst_busy", busy, 0); chk("rst_int", uart_int_out, 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 3; i <= 10; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    do_reset();

    // Idle with strobes every cycle, then 0x55 start bit and first data bit
    cnt_int = 0; cnt_busy = 0;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ld, tbl[i].din, tbl[i].en);
      chk("tbl_txd", txd, tbl[i].txd);
      chk("tbl_ts", ts, tbl[i].ts);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_int", uart_int_out, tbl[i].irq);
    end
    drain(1, 200);
    chk("f55_irq_count", cnt_int, 1);
    chk("f55_busy_cycles", cnt_busy, 80);

    // 0xA3 then 0x0F queued during data bits: two contiguous frames
    cnt_int = 0; cnt_busy = 0;
    step(1'b1, 8'hA3, 1'b1);
    repeat (40) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h0F, 1'b1);
    chk("queued_ts", ts, 0);
    drain(1, 400);
    chk("b2b_irq_count", cnt_int, 2);
    chk("b2b_busy_cycles", cnt_busy, 160);

    // 0x33 arrives while 0x22 still waits and must be dropped
    cnt_int = 0; cnt_busy = 0;
    step(1'b1, 8'h11, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    chk("drop_ts", ts, 0);
    drain(1, 400);
    chk("drop_irq_count", cnt_int, 2);
    chk("drop_busy_cycles", cnt_busy, 160);

    // Strobe every 4th cycle stretches the frame to 320 clocks
    cnt_int = 0; cnt_busy = 0;
    step(1'b1, 8'hFF, 1'b0);
    drain(4, 1000);
    chk("slow_irq_count", cnt_int, 1);
    chk("slow_busy_cycles", cnt_busy, 320);

    // Asynchronous reset in the middle of data bit 3 of a 0x00 frame
    step(1'b1, 8'h00, 1'b1);
    repeat (37) step(1'b0, 8'h00, 1'b1);
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ts", ts, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cnt_int = 0; cnt_busy = 0;
    repeat (100) step(1'b0, 8'h00, 1'b1);
    chk("post_rst_irq_count", cnt_int, 0);
    chk("post_rst_busy_cycles", cnt_busy, 0);

    // Random traffic, including stretches without strobes
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end
    drain(1, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
